vga_text_render: RTL and testbench

- Parametrised, pipelined pixel renderer for the falling-character typing game.
- Converts the VGA controller's current pixel address into 24-bit RGB. Sources are an external character-slot memory and an external font ROM, both synchronous-read.
- Draws the falling glyph field plus four HUD fields: FPS label, score, elapsed time and miss count.
- Owns the elapsed-time counter, which is frame-based and can be paused.

---
 rtl/vga_text_render_if.sv | 23 ++
 rtl/vga_text_render.sv | 184 ++++++++++++++++++
 tb/tb_vga_text_render.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_render_if.sv
// Memory-side bus of the text renderer: character-slot RAM read port and font ROM read port.
// Both memories are synchronous-read; data returns one cycle after the address.
interface vga_text_render_if #(
  parameter int FONT_W = 12,
  parameter int LINE_W = 4
);
  logic [6:0]            slot_idx;
  logic [7:0]            slot_ascii;
  logic [9:0]            slot_row;
  logic                  slot_valid;
  logic [8+LINE_W-1:0]   font_addr;
  logic [FONT_W-1:0]     font_data;

  modport master (
    output slot_idx, font_addr,
    input  slot_ascii, slot_row, slot_valid, font_data
  );

  modport slave (
    input  slot_idx, font_addr,
    output slot_ascii, slot_row, slot_valid, font_data
  );
endinterface

// File: rtl/vga_text_render.sv
// Three-stage pixel renderer for the falling-character game: slot glyphs plus HUD text fields.
// Also owns the frame-based elapsed-seconds counter shown in the right HUD.
module vga_text_render #(
  parameter int CHAR_W = 9,
  parameter int CHAR_H = 16,
  parameter int FONT_W = 12,
  parameter int COLS   = 71,
  parameter int HUD_L  = 5,
  parameter int HUD_R  = 3,
  parameter int V_RES  = 480,
  parameter int FPS    = 60,
  parameter int VAL_W  = 10
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic                 pause,
  input  logic [VAL_W-1:0]     score,
  input  logic [VAL_W-1:0]     miss,
  input  logic [9:0]           vga_haddr,
  input  logic [9:0]           vga_vaddr,
  vga_text_render_if.master    mem,
  output logic [23:0]          vga_data,
  output logic [9:0]           time_sec
);

  localparam int LW      = $clog2(CHAR_H);
  localparam int PX_W    = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int FC_W    = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int R_FIRST = COLS - HUD_R;

  typedef enum logic [1:0] {R_NONE, R_SLOT, R_HUDL, R_HUDR} region_t;

  function automatic logic [9:0] sat999(input logic [VAL_W-1:0] v);
    if (32'(v) > 32'd999) return 10'd999;
    return 10'(v);
  endfunction

  function automatic logic [7:0] digit(input logic [9:0] v, input logic [6:0] pos);
    logic [9:0] d;
    case (pos)
      7'd0:    d = v / 10'd100;
      7'd1:    d = (v / 10'd10) % 10'd10;
      default: d = v % 10'd10;
    endcase
    return 8'h30 + 8'(d);
  endfunction

  function automatic logic [7:0] fps_char(input logic [6:0] pos);
    case (pos)
      7'd0:    return 8'h36;
      7'd1:    return 8'h30;
      7'd2:    return 8'h46;
      7'd3:    return 8'h50;
      7'd4:    return 8'h53;
      default: return 8'h20;
    endcase
  endfunction

  logic [6:0]      col_s0;
  logic [PX_W-1:0] px_s0;
  region_t         region_s0;

  always_comb begin
    col_s0 = 7'(vga_haddr / 10'(CHAR_W));
    px_s0  = PX_W'(vga_haddr % 10'(CHAR_W));
    if (col_s0 < 7'(HUD_L))        region_s0 = R_HUDL;
    else if (col_s0 < 7'(R_FIRST)) region_s0 = R_SLOT;
    else if (col_s0 < 7'(COLS))    region_s0 = R_HUDR;
    else                           region_s0 = R_NONE;
    mem.slot_idx = (region_s0 == R_SLOT) ? col_s0 - 7'(HUD_L) : 7'd0;
  end

  logic [6:0]      col_s1;
  logic [PX_W-1:0] px_s1;
  logic [9:0]      vaddr_s1;
  region_t         region_s1;

  logic [10:0]     v_ext, row_lo, row_hi;
  logic            hit, top, bot;
  logic [6:0]      hud_col;
  logic [LW-1:0]   slot_line, bot_line, line_s1;
  logic [7:0]      ascii_s1;
  logic [23:0]     colour_s1;
  logic            draw_s1;

  // 11-bit compare keeps a slot parked near line 1023 from wrapping onto the top lines
  always_comb begin
    v_ext     = {1'b0, vaddr_s1};
    row_lo    = {1'b0, mem.slot_row};
    row_hi    = row_lo + 11'(CHAR_H);
    hit       = mem.slot_valid && (v_ext >= row_lo) && (v_ext < row_hi);
    slot_line = LW'(vaddr_s1 - mem.slot_row);
    top       = vaddr_s1 < 10'(CHAR_H);
    bot       = vaddr_s1 >= 10'(V_RES - CHAR_H);
    bot_line  = LW'(vaddr_s1 - 10'(V_RES - CHAR_H));
    hud_col   = (region_s1 == R_HUDR) ? col_s1 - 7'(R_FIRST) : col_s1;
    ascii_s1  = 8'h20;
    line_s1   = LW'(vaddr_s1);
    colour_s1 = 24'h000000;
    draw_s1   = 1'b0;
    case (region_s1)
      R_SLOT: begin
        ascii_s1  = mem.slot_ascii;
        line_s1   = slot_line;
        colour_s1 = 24'hFFFFFF;
        draw_s1   = hit;
      end
      R_HUDL: begin
        if (top) begin
          ascii_s1  = fps_char(hud_col);
          colour_s1 = 24'h00FFFF;
          draw_s1   = 1'b1;
        end else if (bot && hud_col < 7'd3) begin
          ascii_s1  = digit(sat999(score), hud_col);
          line_s1   = bot_line;
          colour_s1 = 24'h00FF00;
          draw_s1   = 1'b1;
        end
      end
      R_HUDR: begin
        if (top) begin
          ascii_s1  = digit(time_sec, hud_col);
          colour_s1 = 24'hFFFF00;
          draw_s1   = 1'b1;
        end else if (bot) begin
          ascii_s1  = digit(sat999(miss), hud_col);
          line_s1   = bot_line;
          colour_s1 = 24'hFF0000;
          draw_s1   = 1'b1;
        end
      end
      default: ;
    endcase
    mem.font_addr = {ascii_s1, line_s1};
  end

  logic [PX_W-1:0] px_s2;
  logic [23:0]     colour_s2;
  logic            draw_s2;
  logic            pix_on;

  assign pix_on = draw_s2 && (32'(px_s2) < FONT_W) && mem.font_data[px_s2];

  logic            at_origin, prev_origin, frame_pulse;
  logic [FC_W-1:0] frame_cnt;

  assign at_origin   = (vga_haddr == 10'd0) && (vga_vaddr == 10'd0);
  assign frame_pulse = at_origin && !prev_origin;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      col_s1      <= '0;
      px_s1       <= '0;
      vaddr_s1    <= '0;
      region_s1   <= R_NONE;
      px_s2       <= '0;
      colour_s2   <= '0;
      draw_s2     <= 1'b0;
      vga_data    <= '0;
      prev_origin <= 1'b0;
      frame_cnt   <= '0;
      time_sec    <= '0;
    end else begin
      col_s1      <= col_s0;
      px_s1       <= px_s0;
      vaddr_s1    <= vga_vaddr;
      region_s1   <= region_s0;
      px_s2       <= px_s1;
      colour_s2   <= colour_s1;
      draw_s2     <= draw_s1;
      vga_data    <= pix_on ? colour_s2 : 24'h000000;
      prev_origin <= at_origin;
      if (frame_pulse && !pause) begin
        if (frame_cnt == FC_W'(FPS - 1)) begin
          frame_cnt <= '0;
          if (time_sec != 10'd999) time_sec <= time_sec + 10'd1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render: pixel vectors with hand-computed font addresses and colours,
// plus latency, reset and elapsed-time sequences (second instance with a short frame rate).
module tb_vga_text_render;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b0;
  logic        pause   = 1'b0;
  logic [9:0]  score   = '0;
  logic [9:0]  miss    = '0;
  logic [9:0]  haddr   = 10'd5;
  logic [9:0]  vaddr   = 10'd5;
  logic [23:0] vga_data;
  logic [9:0]  time_sec;

  logic [9:0]  h2 = 10'd5;
  logic [9:0]  v2 = 10'd5;
  logic [23:0] vga_data2;
  logic [9:0]  time_sec2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vga_clk = ~vga_clk;

  vga_text_render_if #(.FONT_W(12), .LINE_W(4)) bus ();
  vga_text_render_if #(.FONT_W(12), .LINE_W(4)) bus2 ();

  vga_text_render dut (
    .vga_clk(vga_clk), .reset(reset), .pause(pause), .score(score), .miss(miss),
    .vga_haddr(haddr), .vga_vaddr(vaddr), .mem(bus), .vga_data(vga_data), .time_sec(time_sec)
  );

  vga_text_render #(.FPS(2)) dut2 (
    .vga_clk(vga_clk), .reset(reset), .pause(1'b0), .score(score), .miss(miss),
    .vga_haddr(h2), .vga_vaddr(v2), .mem(bus2), .vga_data(vga_data2), .time_sec(time_sec2)
  );

  assign bus2.slot_ascii = 8'h00;
  assign bus2.slot_row   = 10'd0;
  assign bus2.slot_valid = 1'b0;
  assign bus2.font_data  = 12'h000;

  // external memory models
  logic [7:0]  s_ascii [128];
  logic [9:0]  s_row   [128];
  logic        s_valid [128];
  logic [11:0] font_mem [4096];

  always @(posedge vga_clk) begin
    bus.slot_ascii <= s_ascii[bus.slot_idx];
    bus.slot_row   <= s_row[bus.slot_idx];
    bus.slot_valid <= s_valid[bus.slot_idx];
    bus.font_data  <= font_mem[bus.font_addr];
  end

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [9:0]  sc;
    logic [6:0]  si;
    logic        chk_fa;
    logic [11:0] fa;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int h, int v, int sc, int si, int chk, int fa, int rgb);
    vec_t t;
    t.h = 10'(h); t.v = 10'(v); t.sc = 10'(sc); t.si = 7'(si);
    t.chk_fa = 1'(chk); t.fa = 12'(fa); t.rgb = 24'(rgb);
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulses(input int n, input bit which);
    for (int i = 0; i < n; i++) begin
      if (which) begin h2 = 10'd1; v2 = 10'd0; end
      else begin haddr = 10'd1; vaddr = 10'd0; end
      tick;
      if (which) begin h2 = 10'd0; v2 = 10'd0; end
      else begin haddr = 10'd0; vaddr = 10'd0; end
      tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      s_ascii[i] = 8'h00; s_row[i] = 10'd0; s_valid[i] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) font_mem[i] = 12'h155;
    font_mem[12'h414] = 12'h001;
    s_ascii[10] = 8'h41; s_row[10] = 10'd100;  s_valid[10] = 1'b1;
    s_ascii[20] = 8'h42; s_row[20] = 10'd1020; s_valid[20] = 1'b1;
    s_ascii[21] = 8'h43; s_row[21] = 10'd0;    s_valid[21] = 1'b1;
    s_ascii[22] = 8'h44; s_row[22] = 10'd100;  s_valid[22] = 1'b0;
    s_ascii[62] = 8'h45; s_row[62] = 10'd200;  s_valid[62] = 1'b1;

    //  h    v    score si chk fa      rgb
    add(135, 104, 1000, 10, 1, 'h414, 'hFFFFFF);
    add(137, 104, 1000, 10, 1, 'h414, 'h000000);
    add(135, 115, 1000, 10, 1, 'h41F, 'hFFFFFF);
    add(136, 115, 1000, 10, 1, 'h41F, 'h000000);
    add(135, 116, 1000, 10, 0, 0,     'h000000);
    add(135, 99,  1000, 10, 0, 0,     'h000000);
    add(243, 104, 1000, 22, 1, 'h444, 'h000000);
    add(225, 2,   1000, 20, 0, 0,     'h000000);
    add(225, 1021,1000, 20, 1, 'h421, 'hFFFFFF);
    add(234, 15,  1000, 21, 1, 'h43F, 'hFFFFFF);
    add(234, 16,  1000, 21, 0, 0,     'h000000);
    add(603, 210, 1000, 62, 1, 'h45A, 'hFFFFFF);
    add(45,  210, 1000, 0,  0, 0,     'h000000);
    add(0,   3,   1000, 0,  1, 'h363, 'h00FFFF);
    add(22,  3,   1000, 0,  1, 'h463, 'h00FFFF);
    add(37,  3,   1000, 0,  1, 'h533, 'h000000);
    add(0,   470, 1000, 0,  1, 'h396, 'h00FF00);
    add(9,   464, 1000, 0,  1, 'h390, 'h00FF00);
    add(18,  479, 1023, 0,  1, 'h39F, 'h00FF00);
    add(0,   470, 123,  0,  1, 'h316, 'h00FF00);
    add(9,   470, 123,  0,  1, 'h326, 'h00FF00);
    add(18,  470, 123,  0,  1, 'h336, 'h00FF00);
    add(27,  470, 123,  0,  0, 0,     'h000000);
    add(9,   200, 123,  0,  0, 0,     'h000000);
    add(612, 470, 123,  0,  1, 'h306, 'hFF0000);
    add(614, 470, 123,  0,  1, 'h306, 'hFF0000);
    add(621, 470, 123,  0,  1, 'h306, 'hFF0000);
    add(630, 470, 123,  0,  1, 'h376, 'hFF0000);
    add(630, 5,   123,  0,  1, 'h305, 'hFFFF00);
    add(639, 5,   123,  0,  0, 0,     'h000000);

    // reset held with random inputs
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      haddr = 10'($urandom_range(0, 1023));
      vaddr = 10'($urandom_range(0, 1023));
      score = 10'($urandom_range(0, 1023));
      miss  = 10'($urandom_range(0, 1023));
      pause = 1'($urandom_range(0, 1));
      tick;
      check("rst_vga_data", 32'(vga_data), 32'h0);
      check("rst_time_sec", 32'(time_sec), 32'h0);
    end
    pause = 1'b0; score = 10'd1000; miss = 10'd7;
    haddr = 10'd135; vaddr = 10'd104;
    @(negedge vga_clk);
    reset = 1'b1;
    tick; tick;
    check("post_rst_2cyc", 32'(vga_data), 32'h0);
    tick;
    check("post_rst_3cyc", 32'(vga_data), 32'hFFFFFF);

    // single-cycle hit between blank pixels
    haddr = 10'd137;
    for (int i = 0; i < 4; i++) tick;
    haddr = 10'd135;
    tick;
    haddr = 10'd137;
    tick;
    check("lat_2cyc", 32'(vga_data), 32'h0);
    tick;
    check("lat_3cyc", 32'(vga_data), 32'hFFFFFF);
    tick;
    check("lat_4cyc", 32'(vga_data), 32'h0);

    foreach (vecs[i]) begin
      haddr = vecs[i].h; vaddr = vecs[i].v; score = vecs[i].sc;
      #1;
      check($sformatf("vec%0d slot_idx", i), 32'(bus.slot_idx), 32'(vecs[i].si));
      tick;
      if (vecs[i].chk_fa) check($sformatf("vec%0d font_addr", i), 32'(bus.font_addr), 32'(vecs[i].fa));
      tick; tick;
      check($sformatf("vec%0d rgb", i), 32'(vga_data), 32'(vecs[i].rgb));
    end

    // elapsed time on the 60-frame instance
    haddr = 10'd5; vaddr = 10'd5;
    tick;
    pulses(119, 1'b0);
    check("time_119", 32'(time_sec), 32'd1);
    pulses(1, 1'b0);
    check("time_120", 32'(time_sec), 32'd2);
    pause = 1'b1;
    pulses(60, 1'b0);
    check("time_paused", 32'(time_sec), 32'd2);
    pause = 1'b0;
    pulses(60, 1'b0);
    check("time_resumed", 32'(time_sec), 32'd3);

    // mid-run reset
    haddr = 10'd5; vaddr = 10'd5;
    @(negedge vga_clk);
    reset = 1'b0;
    #1;
    check("midrst_time", 32'(time_sec), 32'd0);
    tick;
    @(negedge vga_clk);
    reset = 1'b1;

    // static origin on the 2-frame instance counts as a single frame
    h2 = 10'd0; v2 = 10'd0;
    for (int i = 0; i < 100; i++) tick;
    check("static_hold", 32'(time_sec2), 32'd0);
    pulses(1, 1'b1);
    check("static_next", 32'(time_sec2), 32'd1);
    pulses(1994, 1'b1);
    check("time2_998", 32'(time_sec2), 32'd998);
    pulses(2, 1'b1);
    check("time2_999", 32'(time_sec2), 32'd999);
    pulses(20, 1'b1);
    check("time2_sat", 32'(time_sec2), 32'd999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
